// File: rtl/cpu_io_pkg.sv
// Shared CPU I/O types and constants: byte type, default port addresses and
// the bit layout of the output-port status word.
package cpu_io_pkg;

    typedef logic [7:0] byte_t;

    localparam byte_t PORT_ADDR_DEF = 8'hFF;
    localparam byte_t STAT_ADDR_DEF = 8'hFE;

    localparam int unsigned STAT_OVF_BIT   = 15;
    localparam int unsigned STAT_FULL_BIT  = 8;
    localparam int unsigned STAT_EMPTY_BIT = 7;
    localparam int unsigned STAT_CNT_LSB   = 0;
    localparam int unsigned STAT_CNT_W     = 7;

    function automatic logic [15:0] stat_word(input logic                  ovf,
                                              input logic                  full,
                                              input logic                  empty,
                                              input logic [STAT_CNT_W-1:0] cnt);
        logic [15:0] w;
        w                                            = '0;
        w[STAT_OVF_BIT]                              = ovf;
        w[STAT_FULL_BIT]                             = full;
        w[STAT_EMPTY_BIT]                            = empty;
        w[STAT_CNT_LSB +: STAT_CNT_W]                = cnt;
        return w;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x 8 storage for the output-port FIFO: synchronous write, asynchronous read.
module fifo_mem
    import cpu_io_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  byte_t         i_wdata,
    input  logic [AW-1:0] i_raddr,
    output byte_t         o_rdata
);

    byte_t r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/output_port_fifo.sv
// Memory-mapped CPU output port backed by a FIFO with valid/ready drain side.
// Define OUTPUT_PORT_OVF_EN to add a sticky overflow bit in stat_rd[15].
module output_port_fifo
    import cpu_io_pkg::*;
#(
    parameter byte_t       PORT_ADDR = PORT_ADDR_DEF,
    parameter byte_t       STAT_ADDR = STAT_ADDR_DEF,
    parameter int unsigned DEPTH     = 8
) (
    input  logic                     clk,
    input  logic                     CLR,
    input  logic                     we,
    input  logic [7:0]               addr,
    input  logic [15:0]              din,
    output logic [15:0]              stat_rd,
    output logic                     stat_sel,
    output logic [7:0]               port_data,
    output logic                     port_valid,
    input  logic                     port_ready,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    if ((DEPTH < 2) || (DEPTH > 64) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("output_port_fifo: DEPTH must be a power of two in 2..64");
    end

    logic [PW-1:0] r_wr_ptr, r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [15:0]   r_stat_rd;

    logic [PW-1:0] w_wr_ptr_d, w_rd_ptr_d;
    logic [CW-1:0] w_count_d;
    logic [15:0]   w_stat_d;
    logic          w_push_req, w_push, w_pop;
    logic          w_ovf_d;
    byte_t         w_rdata;

    // Upper write-data byte carries no information for this port.
    logic w_unused_din_hi;
    assign w_unused_din_hi = ^din[15:8];

    assign empty      = (r_count == '0);
    assign full       = (r_count == FULL_CNT);
    assign count      = r_count;
    assign port_valid = ~empty;
    assign port_data  = w_rdata;
    assign stat_rd    = r_stat_rd;
    assign stat_sel   = (addr == STAT_ADDR) && !we;

    assign w_push_req = we && (addr == PORT_ADDR);
    assign w_pop      = port_valid && port_ready;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign w_push     = w_push_req && (!full || w_pop);

`ifdef OUTPUT_PORT_OVF_EN
    logic r_ovf;
    logic w_drop;

    assign w_drop  = w_push_req && full && !w_pop;
    assign w_ovf_d = r_ovf | w_drop;

    always_ff @(posedge clk or posedge CLR) begin
        if (CLR) begin
            r_ovf <= 1'b0;
        end else begin
            r_ovf <= w_ovf_d;
        end
    end
`else
    assign w_ovf_d = 1'b0;
`endif

    always_comb begin
        w_wr_ptr_d = r_wr_ptr;
        w_rd_ptr_d = r_rd_ptr;
        w_count_d  = r_count;
        if (w_push) begin
            w_wr_ptr_d = r_wr_ptr + PW'(1);
        end
        if (w_pop) begin
            w_rd_ptr_d = r_rd_ptr + PW'(1);
        end
        unique case ({w_push, w_pop})
            2'b10:   w_count_d = r_count + CW'(1);
            2'b01:   w_count_d = r_count - CW'(1);
            default: w_count_d = r_count;
        endcase
        // Status mirrors the post-edge state so a CPU read sees it one cycle later.
        w_stat_d = stat_word(w_ovf_d, (w_count_d == FULL_CNT), (w_count_d == '0),
                             STAT_CNT_W'(w_count_d));
    end

    always_ff @(posedge clk or posedge CLR) begin
        if (CLR) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_stat_rd <= stat_word(1'b0, 1'b0, 1'b1, '0);
        end else begin
            r_wr_ptr  <= w_wr_ptr_d;
            r_rd_ptr  <= w_rd_ptr_d;
            r_count   <= w_count_d;
            r_stat_rd <= w_stat_d;
        end
    end

    fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (din[7:0]),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

endmodule

// File: tb/tb_output_port_fifo.sv
// Scoreboard bench for output_port_fifo: directed pushes queue expected bytes,
// a negedge monitor checks every accepted pop against the queue.
module tb_output_port_fifo;

    logic        clk = 1'b0;
    logic        CLR;
    logic        we;
    logic [7:0]  addr;
    logic [15:0] din;
    logic [15:0] stat_rd;
    logic        stat_sel;
    logic [7:0]  port_data;
    logic        port_valid;
    logic        port_ready;
    logic        full, empty;
    logic [3:0]  count;

    int total = 0;
    int bad   = 0;
    logic [7:0]  sb[$];
    logic [15:0] ovf_bit = 16'h0000;

    output_port_fifo dut (
        .clk        (clk),
        .CLR        (CLR),
        .we         (we),
        .addr       (addr),
        .din        (din),
        .stat_rd    (stat_rd),
        .stat_sel   (stat_sel),
        .port_data  (port_data),
        .port_valid (port_valid),
        .port_ready (port_ready),
        .full       (full),
        .empty      (empty),
        .count      (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // A transfer is committed at the next rising edge; inputs are stable here.
    always @(negedge clk) begin
        if (!CLR && port_valid === 1'b1 && port_ready === 1'b1) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL pop_unexpected: got %h expected none", port_data);
            end else begin
                logic [7:0] exp_b;
                exp_b = sb.pop_front();
                if (port_data !== exp_b) begin
                    bad++;
                    $display("FAIL pop_order: got %h expected %h", port_data, exp_b);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [7:0] a, input logic [7:0] b);
        we   = 1'b1;
        addr = a;
        din  = {8'hC3, b};
        tick();
        we   = 1'b0;
        addr = 8'h00;
    endtask

    task automatic drain(input string name);
        port_ready = 1'b1;
        for (int i = 0; i < 40 && empty !== 1'b1; i++) tick();
        check({name, "_empty"}, {15'd0, empty}, 16'd1);
        check({name, "_sb_left"}, 16'(sb.size()), 16'd0);
        port_ready = 1'b0;
    endtask

    initial begin
        CLR        = 1'b1;
        we         = 1'b0;
        addr       = 8'h00;
        din        = 16'h0000;
        port_ready = 1'b0;
        repeat (2) tick();
        check("rst_empty", {15'd0, empty}, 16'd1);
        check("rst_full", {15'd0, full}, 16'd0);
        check("rst_valid", {15'd0, port_valid}, 16'd0);
        check("rst_count", {12'd0, count}, 16'd0);
        check("rst_stat", stat_rd, 16'h0080);
        CLR = 1'b0;
        repeat (2) tick();
        check("idle_stat", stat_rd, 16'h0080);

        // Single byte, latency and hold
        write(8'hFF, 8'h5A);
        sb.push_back(8'h5A);
        check("lat_valid", {15'd0, port_valid}, 16'd1);
        check("lat_data", {8'd0, port_data}, 16'h005A);
        check("lat_count", {12'd0, count}, 16'd1);
        check("lat_stat", stat_rd, 16'h0001);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_data", {7'd0, port_valid, port_data}, 16'h015A);
        end
        drain("single");

        // Fill, overflow, drain in order
        for (int i = 1; i <= 8; i++) begin
            write(8'hFF, 8'(i));
            sb.push_back(8'(i));
        end
        check("fill_full", {15'd0, full}, 16'd1);
        check("fill_count", {12'd0, count}, 16'd8);
        check("fill_stat", stat_rd, 16'h0108);
        write(8'hFF, 8'h09);
`ifdef OUTPUT_PORT_OVF_EN
        ovf_bit = 16'h8000;
`endif
        check("ovf_count", {12'd0, count}, 16'd8);
        check("ovf_stat", stat_rd, 16'h0108 | ovf_bit);
        check("ovf_head", {8'd0, port_data}, 16'h0001);
        drain("fill");

        // Full with simultaneous push and pop
        for (int i = 0; i < 8; i++) begin
            write(8'hFF, 8'h11 + 8'(i));
            sb.push_back(8'h11 + 8'(i));
        end
        port_ready = 1'b1;
        sb.push_back(8'hAA);
        write(8'hFF, 8'hAA);
        port_ready = 1'b0;
        check("pp_count", {12'd0, count}, 16'd8);
        check("pp_full", {15'd0, full}, 16'd1);
        check("pp_head", {8'd0, port_data}, 16'h0012);
        check("pp_stat", stat_rd, 16'h0108 | ovf_bit);
        drain("pp");

        // Foreign address write and status read
        write(8'hFF, 8'h77);
        sb.push_back(8'h77);
        write(8'h10, 8'h33);
        check("foreign_count", {12'd0, count}, 16'd1);
        check("foreign_head", {8'd0, port_data}, 16'h0077);
        write(8'hFE, 8'h44);
        check("wr_stat_count", {12'd0, count}, 16'd1);
        we   = 1'b1;
        addr = 8'hFE;
        #1;
        check("stat_sel_we", {15'd0, stat_sel}, 16'd0);
        we = 1'b0;
        #1;
        check("stat_sel", {15'd0, stat_sel}, 16'd1);
        tick();
        check("stat_rd_cnt", stat_rd, 16'h0001 | ovf_bit);
        addr = 8'h00;
        #1;
        check("stat_sel_off", {15'd0, stat_sel}, 16'd0);

        // CLR mid-drain
        write(8'hFF, 8'h78);
        sb.push_back(8'h78);
        write(8'hFF, 8'h79);
        sb.push_back(8'h79);
        check("q3_count", {12'd0, count}, 16'd3);
        port_ready = 1'b1;
        tick();
        CLR = 1'b1;
        #1;
        check("clr_valid", {15'd0, port_valid}, 16'd0);
        check("clr_count", {12'd0, count}, 16'd0);
        check("clr_stat", stat_rd, 16'h0080);
        sb.delete();
        port_ready = 1'b0;
        ovf_bit    = 16'h0000;
        tick();
        CLR = 1'b0;
        tick();
        check("post_clr_stat", stat_rd, 16'h0080);
        write(8'hFF, 8'h9C);
        sb.push_back(8'h9C);
        check("post_clr_head", {7'd0, port_valid, port_data}, 16'h019C);
        drain("post_clr");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
